// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the SRAM controller.
//   state_e    : controller FSM states
//   SRAM_*_W   : default address/data widths
//   MAX_WAIT   : largest supported WAIT_CYCLES value
//   cnt_width  : wait-counter width for a given WAIT_CYCLES
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD
    } state_e;

    localparam int unsigned SRAM_ADDR_W = 8;
    localparam int unsigned SRAM_DATA_W = 8;
    localparam int unsigned MAX_WAIT    = 15;

    // max(1, clog2(wait_cycles + 1))
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles == 0) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Loadable down-counter used to time memory strobe phases.
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (has priority over dec)
//   load_val  : value loaded on load
//   dec       : decrement by one; holds at zero
//   zero      : count is zero
module sram_wait_cnt #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Single-word SRAM controller: accepts a read/write command over valid/ready
// and runs a setup / strobe / hold sequence on the SRAM pins. Reads return the
// sampled data on a one-cycle response pulse; writes also pulse rsp_valid.
//   clk, rst               : clock, synchronous active-high reset
//   cmd_valid/ready        : command handshake
//   cmd_we/addr/wdata      : command fields (sampled only on accept)
//   rsp_valid/is_read/rdata: completion pulse, op type, read data
//   sram_cs/wr/rd/addr/din : SRAM pins (all registered)
//   sram_dout              : SRAM read data
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = SRAM_ADDR_W,
    parameter int unsigned DATA_W      = SRAM_DATA_W,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_is_read,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

    if (WAIT_CYCLES > MAX_WAIT) begin : g_wait_check
        $error("sram_ctrl: WAIT_CYCLES exceeds MAX_WAIT");
    end

    state_e state;
    logic   lat_we;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // Counter is loaded while in SETUP so it holds WAIT_CYCLES in the first
    // ACCESS cycle; ACCESS then lasts WAIT_CYCLES+1 cycles.
    assign cnt_load = (state == S_SETUP);
    assign cnt_dec  = (state == S_ACCESS) && !cnt_zero;

    sram_wait_cnt #(
        .WIDTH (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_W'(WAIT_CYCLES)),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // sram_addr/sram_din double as the command address/data latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_we      <= 1'b0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_is_read <= 1'b0;
            rsp_rdata   <= '0;
            sram_cs     <= 1'b0;
            sram_wr     <= 1'b0;
            sram_rd     <= 1'b0;
            sram_addr   <= '0;
            sram_din    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        state     <= S_SETUP;
                        cmd_ready <= 1'b0;
                        lat_we    <= cmd_we;
                        sram_cs   <= 1'b1;
                        sram_addr <= cmd_addr;
                        sram_din  <= cmd_wdata;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    state   <= S_ACCESS;
                    sram_wr <= lat_we;
                    sram_rd <= ~lat_we;
                end
                S_ACCESS: begin
                    if (cnt_zero) begin
                        state       <= S_HOLD;
                        sram_wr     <= 1'b0;
                        sram_rd     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_is_read <= ~lat_we;
                        if (!lat_we) begin
                            rsp_rdata <= sram_dout;
                        end
                    end
                end
                S_HOLD: begin
                    state       <= S_IDLE;
                    rsp_valid   <= 1'b0;
                    rsp_is_read <= 1'b0;
                    sram_cs     <= 1'b0;
                    sram_addr   <= '0;
                    sram_din    <= '0;
                    cmd_ready   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Host-side controller for the `sram` model. It accepts single-word read or write commands over a valid/ready handshake and drives the SRAM's `cs`, `wr`, `rd`, `addr` and `din` pins with a fixed setup/strobe/hold sequence. For reads, it samples the SRAM's `dout` and returns it on a one-cycle response strobe. It sits between any bus master (test sequencer, DMA, CPU port) and the asynchronous-style SRAM, so no master ever toggles SRAM pins directly.

## Interface
Parameters:
- `ADDR_W`, 8, SRAM address width
- `DATA_W`, 8, SRAM data width
- `WAIT_CYCLES`, 1, extra strobe cycles beyond the first; legal range 0–15

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_we`  in  1  1 = write, 0 = read
- `cmd_addr`  in  ADDR_W  target address
- `cmd_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle completion pulse, for reads and writes
- `rsp_is_read`  out  1  completed op was a read; valid while `rsp_valid` is high
- `rsp_rdata`  out  DATA_W  read data; valid while `rsp_valid && rsp_is_read`
- `sram_cs`  out  1  chip select to SRAM
- `sram_wr`  out  1  write strobe
- `sram_rd`  out  1  read strobe
- `sram_addr`  out  ADDR_W  SRAM address
- `sram_din`  out  DATA_W  data to SRAM
- `sram_dout`  in  DATA_W  data from SRAM

## Operation
- **FSM states:** IDLE → SETUP → ACCESS → HOLD → IDLE.
- **IDLE**
  - `cmd_ready`=1; all SRAM pins are 0.
  - Accept on `cmd_valid && cmd_ready`: latch `cmd_we`, `cmd_addr` and `cmd_wdata` into internal registers, then go to SETUP.
  - Command inputs are ignored outside the accept cycle.
- **SETUP** (1 cycle)
  - `sram_cs`=1; `sram_addr` and `sram_din` driven from the latches; `sram_wr`=`sram_rd`=0.
- **ACCESS** (WAIT_CYCLES+1 cycles)
  - `sram_cs`=1; `sram_wr`=latched `we`, `sram_rd`=latched `~we`. Addr and data are held.
  - A down-counter loads WAIT_CYCLES on entry and exits to HOLD when it reads 0.
  - On the final ACCESS edge, a read captures `sram_dout` into `rsp_rdata`.
- **HOLD** (1 cycle)
  - Strobes are 0; `sram_cs`, `sram_addr` and `sram_din` are still held.
  - `rsp_valid`=1 and `rsp_is_read`=~we.
  - Next state is IDLE.
- **Invariants**
  - `sram_wr && sram_rd` is never true.
  - Strobes are never high outside ACCESS.
  - `cmd_ready` is 1 only in IDLE.
- **Arithmetic:** the wait counter width is max(1, $clog2(WAIT_CYCLES+1)). There is no address arithmetic; the address passes through unmodified.

## Timing
- **Reset:** with `rst`=1 at an edge, the next state is IDLE. All outputs are 0 except `cmd_ready`, which is 1 in the cycle after reset deasserts.
- **Reset mid-operation:** aborts the access. `sram_cs`/`sram_wr`/`sram_rd` drop at that edge, and no `rsp_valid` is issued for the aborted command.
- **Latency:** accept at edge N; SETUP at N+1; ACCESS at N+2 … N+2+WAIT_CYCLES; HOLD with `rsp_valid` at N+3+WAIT_CYCLES; `cmd_ready` again at N+4+WAIT_CYCLES.
- **Throughput:** one command per WAIT_CYCLES+4 cycles.
- **Held command:** `cmd_valid` held high through a busy period is accepted exactly once per IDLE visit. Back-to-back commands have no overlap.
- **Read capture:** `rsp_rdata` holds the captured read value until the next read capture. Writes do not change `rsp_rdata`.

## Structure
- **Package `sram_ctrl_pkg`:**
  - FSM state enum: `S_IDLE`, `S_SETUP`, `S_ACCESS`, `S_HOLD`
  - default `ADDR_W`/`DATA_W` constants
  - `MAX_WAIT`=15
- **Sub-module `sram_wait_cnt`:** loadable down-counter with `load`, `load_val` and `zero` outputs. It is reusable by other memory controllers.
- **Top:** FSM, command latches and read-data register live in `sram_ctrl`.
- **Assertion:** a parameter check fails elaboration if WAIT_CYCLES > MAX_WAIT.

## Test plan
- **Write/read pair:** write `addr`=0x5A, `wdata`=0xA5, then read 0x5A → read `rsp_valid` with `rsp_is_read`=1 and `rsp_rdata`=0xA5. For WAIT_CYCLES=1, `sram_wr` is high for exactly 2 cycles, starting 2 cycles after accept.
- **Two addresses:** write 0xA5→0x5A and 0x3C→0xA5, then read 0xA5 → 0x3C and read 0x5A → 0xA5. `rsp_rdata` is unchanged across the intervening write responses.
- **Held valid:** hold `cmd_valid`=1 continuously with 3 queued reads → exactly 3 accepts spaced WAIT_CYCLES+4 cycles apart, and 3 `rsp_valid` pulses.
- **Reset abort:** assert `rst` during ACCESS of a write → `sram_cs`/`sram_wr` are 0 at the next edge, no `rsp_valid`, and `cmd_ready`=1 the cycle after `rst` falls.
- **Zero wait:** with WAIT_CYCLES=0, one read takes 4 cycles accept-to-ready and `sram_rd` is high for 1 cycle.
- **Random traffic:** random we/addr/data for 1000 ops against a scoreboard → no mismatch, `sram_wr && sram_rd` never true, and strobes are never high while `sram_cs`=0.
